// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the ROM port arbiter: pointer width and
// index/one-hot conversion helpers sized for the largest supported NUM_REQ.
package rom_arbiter_pkg;

    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned PTR_W   = $clog2(MAX_REQ);

    // Index to one-hot vector of MAX_REQ bits.
    function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [PTR_W-1:0] idx);
        return MAX_REQ'(1) << idx;
    endfunction

    // One-hot vector to index; OR-reduction, so a zero vector yields index 0.
    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [PTR_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(MAX_REQ); i++) begin
            if (oh[i]) r = r | PTR_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/rom_arbiter_rr_picker.sv
// Round-robin picker: finds the first eligible index at or after rr_ptr,
// wrapping past NUM_REQ-1 to 0.
// Ports: eligible (request mask), rr_ptr (search start) -> found, winner.
module rr_picker
    import rom_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic               found,
    output logic [PTR_W-1:0]   winner
);

    localparam int unsigned DW = 2 * NUM_REQ;

    logic [DW-1:0] doubled;
    logic [DW-1:0] masked;

    // Upper copy covers the wrap; lower copy loses bits below the pointer,
    // so the lowest set bit of the doubled vector is the round-robin winner.
    always_comb begin
        doubled = {eligible, eligible};
        masked  = '0;
        for (int j = 0; j < int'(DW); j++) begin
            masked[j] = doubled[j] && ((j >= int'(NUM_REQ)) || (j >= int'(rr_ptr)));
        end
        found  = 1'b0;
        winner = '0;
        // Descending scan: the last hit written is the lowest set bit.
        for (int j = int'(DW) - 1; j >= 0; j--) begin
            if (masked[j]) begin
                found  = 1'b1;
                winner = PTR_W'(j % int'(NUM_REQ));
            end
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one synchronous-read ROM port among NUM_REQ
// requesters. One read issued per cycle; each read returns with rsp_valid.
// Ports: clock, reset_n; req/addr from requesters; gnt, rsp_valid, rsp_data
// to requesters; rom_enable, rom_address to the ROM, rom_data from it.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned addressBitWidth = 9,
    parameter int unsigned blockLength     = 8
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic [NUM_REQ-1:0]                   req,
    input  logic [NUM_REQ*addressBitWidth-1:0]   addr,
    output logic [NUM_REQ-1:0]                   gnt,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic [blockLength-1:0]               rsp_data,
    output logic                                 rom_enable,
    output logic [addressBitWidth-1:0]           rom_address,
    input  logic [blockLength-1:0]               rom_data
);

    logic [PTR_W-1:0]           rr_ptr;
    logic [PTR_W-1:0]           ptr_next;
    logic [NUM_REQ-1:0]         eligible;
    logic                       found;
    logic [PTR_W-1:0]           winner;
    logic [addressBitWidth-1:0] addr_sel;

    // A requester granted this cycle may still hold req; mask it out.
    assign eligible = req & ~gnt;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .found    (found),
        .winner   (winner)
    );

    // Address mux for the winning requester.
    always_comb begin
        addr_sel = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (winner == PTR_W'(i)) addr_sel = addr[i*addressBitWidth +: addressBitWidth];
        end
    end

    assign ptr_next = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);

    // ROM output already registered; response data passes straight through.
    assign rsp_data = rom_data;

    // Issue and response registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gnt         <= '0;
            rsp_valid   <= '0;
            rom_enable  <= 1'b0;
            rom_address <= '0;
            rr_ptr      <= '0;
        end else begin
            rsp_valid  <= gnt;
            gnt        <= found ? NUM_REQ'(idx_to_onehot(winner)) : '0;
            rom_enable <= found;
            if (found) begin
                rom_address <= addr_sel;
                rr_ptr      <= ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: vector table, hand-written corner
// sequences and random traffic against a round-robin reference model.
module tb_rom_arbiter;

    localparam int N  = 4;
    localparam int AW = 9;
    localparam int DW = 8;

    logic            clock;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            rom_enable;
    logic [AW-1:0]   rom_address;
    logic [DW-1:0]   rom_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    rom_arbiter #(.NUM_REQ(N), .addressBitWidth(AW), .blockLength(DW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .addr        (addr),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rom_enable  (rom_enable),
        .rom_address (rom_address),
        .rom_data    (rom_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ROM contents: word 5 is 0xA3, everything else a simple hash.
    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        logic [7:0] t;
        if (a == 9'h005) return 8'hA3;
        t = a[7:0] * 8'd13;
        return t ^ {a[8], 7'd0} ^ 8'h3C;
    endfunction

    // ROM: synchronous read, enable-gated, zero when not enabled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rom_data <= '0;
        else          rom_data <= rom_enable ? rom_word(rom_address) : '0;
    end

    // Reference model state.
    int            m_ptr;
    logic [N-1:0]  m_gnt;
    logic [N-1:0]  m_rv;
    logic          m_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    task automatic model_reset();
        m_ptr = 0; m_gnt = '0; m_rv = '0; m_en = 1'b0; m_addr = '0; m_data = '0;
    endtask

    // One clock of the arbitration rules, using the inputs seen at the edge.
    task automatic model_step();
        logic [N-1:0]  elig;
        logic [N-1:0]  nrv;
        logic [DW-1:0] nd;
        int win;
        nrv  = m_gnt;
        nd   = m_en ? rom_word(m_addr) : '0;
        elig = req & ~m_gnt;
        win  = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (win < 0 && elig[idx]) win = idx;
        end
        if (win >= 0) begin
            m_gnt  = N'(1 << win);
            m_en   = 1'b1;
            m_addr = addr[win*AW +: AW];
            m_ptr  = (win + 1) % N;
        end else begin
            m_gnt = '0;
            m_en  = 1'b0;
        end
        m_rv   = nrv;
        m_data = nd;
    endtask

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Advance one clock, update the model, then compare on the falling edge.
    task automatic step();
        @(posedge clock);
        cyc++;
        model_step();
        @(negedge clock);
        chk("gnt",         32'(gnt),         32'(m_gnt));
        chk("rsp_valid",   32'(rsp_valid),   32'(m_rv));
        chk("rom_enable",  32'(rom_enable),  32'(m_en));
        chk("rom_address", 32'(rom_address), 32'(m_addr));
        chk("rsp_data",    32'(rsp_data),    32'(m_data));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_gnt"},   32'(gnt),         0);
        chk({name, "_rv"},    32'(rsp_valid),   0);
        chk({name, "_en"},    32'(rom_enable),  0);
        chk({name, "_addr"},  32'(rom_address), 0);
        chk({name, "_data"},  32'(rsp_data),    0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [N-1:0]  req;
        logic [N-1:0]  gnt;
        logic          en;
        logic [AW-1:0] ra;
        logic [N-1:0]  rv;
        logic [DW-1:0] data;
    } vec_t;

    localparam logic [AW-1:0] A0 = 9'h005;
    localparam logic [AW-1:0] A1 = 9'h011;
    localparam logic [AW-1:0] A2 = 9'h122;
    localparam logic [AW-1:0] A3 = 9'h1F3;

    vec_t vt[16];

    initial begin
        req     = '0;
        addr    = {A3, A2, A1, A0};
        reset_n = 1'b0;
        model_reset();
        #1;
        chk_all_zero("rst");
        @(negedge clock);
        reset_n = 1'b1;

        // All four continuous, pointer wrap from 3, requester 2 alone.
        vt[0]  = '{4'b1111, 4'b0001, 1'b1, A0, 4'b0000, 8'h00};
        vt[1]  = '{4'b1111, 4'b0010, 1'b1, A1, 4'b0001, rom_word(A0)};
        vt[2]  = '{4'b1111, 4'b0100, 1'b1, A2, 4'b0010, rom_word(A1)};
        vt[3]  = '{4'b1111, 4'b1000, 1'b1, A3, 4'b0100, rom_word(A2)};
        vt[4]  = '{4'b1111, 4'b0001, 1'b1, A0, 4'b1000, rom_word(A3)};
        vt[5]  = '{4'b0000, 4'b0000, 1'b0, A0, 4'b0001, rom_word(A0)};
        vt[6]  = '{4'b0100, 4'b0100, 1'b1, A2, 4'b0000, 8'h00};
        vt[7]  = '{4'b1001, 4'b1000, 1'b1, A3, 4'b0100, rom_word(A2)};
        vt[8]  = '{4'b1001, 4'b0001, 1'b1, A0, 4'b1000, rom_word(A3)};
        vt[9]  = '{4'b0000, 4'b0000, 1'b0, A0, 4'b0001, 8'hA3};
        vt[10] = '{4'b0000, 4'b0000, 1'b0, A0, 4'b0000, 8'h00};
        vt[11] = '{4'b0100, 4'b0100, 1'b1, A2, 4'b0000, 8'h00};
        vt[12] = '{4'b0100, 4'b0000, 1'b0, A2, 4'b0100, rom_word(A2)};
        vt[13] = '{4'b0100, 4'b0100, 1'b1, A2, 4'b0000, 8'h00};
        vt[14] = '{4'b0100, 4'b0000, 1'b0, A2, 4'b0100, rom_word(A2)};
        vt[15] = '{4'b0000, 4'b0000, 1'b0, A2, 4'b0000, 8'h00};

        for (int i = 0; i < 16; i++) begin
            req = vt[i].req;
            step();
            chk("tbl_gnt",  32'(gnt),         32'(vt[i].gnt));
            chk("tbl_en",   32'(rom_enable),  32'(vt[i].en));
            chk("tbl_addr", 32'(rom_address), 32'(vt[i].ra));
            chk("tbl_rv",   32'(rsp_valid),   32'(vt[i].rv));
            chk("tbl_data", 32'(rsp_data),    32'(vt[i].data));
        end

        // Single request then idle slot, from a fresh reset.
        req = '0;
        do_reset();
        req = 4'b0001;
        step();
        chk("single_gnt",  32'(gnt), 32'h1);
        chk("single_addr", 32'(rom_address), 32'h005);
        chk("single_en",   32'(rom_enable), 1);
        req = 4'b0000;
        step();
        chk("single_rv",   32'(rsp_valid), 32'h1);
        chk("single_data", 32'(rsp_data), 32'hA3);
        chk("idle_en",     32'(rom_enable), 0);
        step();
        chk("idle_rv",     32'(rsp_valid), 0);
        chk("idle_data",   32'(rsp_data), 0);

        // Reset with requester 1's read in flight.
        req = 4'b0010;
        step();
        chk("inflight_gnt", 32'(gnt), 32'h2);
        req = 4'b0000;
        #2 reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        req = 4'b0011;
        step();
        chk("post_rst_gnt", 32'(gnt), 32'h1);
        chk("post_rst_rv",  32'(rsp_valid), 0);
        req = 4'b0000;
        step();
        chk("post_rst_rv2", 32'(rsp_valid), 32'h1);
        step();

        // Random traffic following the requester hold/release rules.
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && m_gnt[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else addr[i*AW +: AW] = AW'($urandom_range(0, 511));
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    addr[i*AW +: AW] = AW'($urandom_range(0, 511));
                end
            end
            step();
        end
        req = '0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Round-robin arbiter that shares one synchronous-read ROM port (1-cycle read latency, enable-gated, output forced to 0 when not enabled) among NUM_REQ requesters. It sits between the lookup clients and the ROM instance. It issues at most one ROM read per cycle and returns each read to its requester with a one-cycle `rsp_valid` tag. Back-to-back reads from different requesters run at full rate.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `addressBitWidth`, 9: ROM address width.
- `blockLength`, 8: ROM data width.

- `clock`  in  1  single clock, all logic on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester level request; held with address stable until `gnt` seen.
- `addr`  in  NUM_REQ*addressBitWidth  flat address bus; requester i occupies bits [i*AW +: AW].
- `gnt`  out  NUM_REQ  registered one-hot pulse; address of that requester has been issued.
- `rsp_valid`  out  NUM_REQ  registered one-hot pulse; `rsp_data` belongs to that requester.
- `rsp_data`  out  blockLength  shared response data, equal to `rom_data` pass-through.
- `rom_enable`  out  1  ROM read enable, registered.
- `rom_address`  out  addressBitWidth  ROM address, registered.
- `rom_data`  in  blockLength  ROM registered output.

## Operation
- Eligible set in cycle t: `req & ~gnt`. A requester granted this cycle is masked, so its still-high `req` cannot be double-served.
- Winner: the first eligible index at or after `rr_ptr`, searching upward and wrapping at NUM_REQ-1 to 0.
- At the end of cycle t, with a winner W:
  - `gnt` <= onehot(W)
  - `rom_enable` <= 1
  - `rom_address` <= addr[W]
  - `rr_ptr` <= (W+1) mod NUM_REQ
- At the end of cycle t with no winner: `gnt` <= 0, `rom_enable` <= 0, `rom_address` holds its value, `rr_ptr` holds.
- `rsp_valid` <= `gnt` (one-cycle delay of the grant). `rsp_data` = `rom_data` combinationally.
- `rsp_data` is meaningful only while some `rsp_valid` bit is 1. It reads 0 in the cycle after an idle issue slot.
- Requester rule: drop `req`, or present a new address, in the cycle after `gnt`. A still-high `req` in that cycle is treated as masked. If it is still high in the following cycle, it is a new request.
- No internal queue. At most two reads are in flight: one in the ROM and one in the issue register.
- Reset (asynchronous assert, synchronous deassert at the clock edge): all outputs 0, `rr_ptr` = 0. In-flight reads are discarded, and no `rsp_valid` is produced for them after reset.

## Timing
- Request seen in cycle t → `gnt` and `rom_enable` high in t+1 → `rsp_valid` and data in t+2. Latency is 2 cycles from request to data.
- Throughput:
  - 1 read/cycle across distinct requesters.
  - 1 read per 2 cycles for a single requester holding `req` continuously.
- `req` arriving in the same cycle as another requester's `gnt` competes normally. The pointer has already advanced past the granted index.
- NUM_REQ=1 is not allowed. Reaching `NUM_REQ` as the pointer wraps to 0.

## Structure
- Shared package: clog2-derived `PTR_W`, and the onehot-to-index and index-to-onehot functions.
- One sub-module, `rr_picker`: combinational inputs (eligible mask, `rr_ptr`), outputs (`found`, winner index). Implemented as a double-width masked priority encoder.
- The top level holds the issue and response registers, the `rr_ptr` register and the address mux.

## Test plan
- Single request: `req`=0001, addr0=0x005, ROM[5]=0xA3 → `gnt`=0001 at t+1 with `rom_address`=0x005 and `rom_enable`=1; `rsp_valid`=0001 with `rsp_data`=0xA3 at t+2.
- All four requesting continuously, `rr_ptr`=0 → `gnt` sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles; each `rsp_valid` follows 1 cycle later with the matching ROM word.
- Requester 2 holding `req` alone → `gnt`=0100 every other cycle, never two consecutive cycles; `rsp_valid`=0100 alternates accordingly.
- Pointer wrap: `rr_ptr`=3, `req`=1001 → 1000 granted first, then 0001. `rr_ptr` goes 0 then 1.
- Idle slot: single request followed by `req`=0 → `rom_enable`=0 on the next issue cycle; `rsp_data`=0 and `rsp_valid`=0 in the cycle after.
- Reset with `gnt`=0010 in flight: assert `reset_n`=0 → all outputs 0 immediately. After release, no `rsp_valid` appears for the discarded read, and the first grant goes to the lowest-index requester.
